// File: rtl/race_compositor_pkg.sv
// Shared game constants, colour values and hit-FSM state encoding for the
// road-race compositor.
package race_compositor_pkg;

    localparam int H_ACTIVE        = 640;
    localparam int V_ACTIVE        = 480;
    localparam int LIVES_INIT      = 3;
    localparam int COOLDOWN_FRAMES = 60;
    localparam int BLINK_SHIFT     = 3;

    localparam logic [11:0] BLACK = 12'h000;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        COOLDOWN = 2'd1,
        OVER     = 2'd2
    } game_state_t;

endpackage

// File: rtl/race_compositor_hit_fsm.sv
// Collision bookkeeping: latches overlaps within a frame, scores at most one
// hit per frame, and runs the lives / cooldown / game-over state machine.
module hit_fsm
    import race_compositor_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       overlap,
    input  logic       frame_end,
    output logic       hit_pulse,
    output logic [2:0] lives,
    output logic       invincible,
    output logic       game_over,
    output logic [1:0] state
);

    game_state_t state_r, state_s;
    logic        hit_seen_r, hit_seen_s;
    logic [7:0]  cool_cnt_r, cool_cnt_s;
    logic [2:0]  lives_r, lives_s;
    logic        hit_pulse_r, hit_pulse_s;
    logic        invincible_r;
    logic        game_over_r;
    logic        hit_now_s;

    // State register; status flags are registered from the next state so they track it exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= PLAY;
            hit_seen_r   <= 1'b0;
            cool_cnt_r   <= 8'd0;
            lives_r      <= 3'(LIVES_INIT);
            hit_pulse_r  <= 1'b0;
            invincible_r <= 1'b0;
            game_over_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            hit_seen_r   <= hit_seen_s;
            cool_cnt_r   <= cool_cnt_s;
            lives_r      <= lives_s;
            hit_pulse_r  <= hit_pulse_s;
            invincible_r <= (state_s == COOLDOWN);
            game_over_r  <= (state_s == OVER);
        end
    end

    // Next-state logic; an overlap on the frame-end pixel itself still counts for that frame.
    always_comb begin
        state_s     = state_r;
        hit_seen_s  = hit_seen_r;
        cool_cnt_s  = cool_cnt_r;
        lives_s     = lives_r;
        hit_pulse_s = 1'b0;
        hit_now_s   = hit_seen_r | overlap;

        case (state_r)
            PLAY: begin
                if (frame_end) begin
                    hit_seen_s = 1'b0;
                    if (hit_now_s) begin
                        hit_pulse_s = 1'b1;
                        if (lives_r <= 3'd1) begin
                            lives_s = 3'd0;
                            state_s = OVER;
                        end else begin
                            lives_s = lives_r - 3'd1;
                            if (COOLDOWN_FRAMES == 0) begin
                                state_s = PLAY;
                            end else begin
                                cool_cnt_s = 8'(COOLDOWN_FRAMES);
                                state_s    = COOLDOWN;
                            end
                        end
                    end else begin
                        state_s = PLAY;
                    end
                end else if (overlap) begin
                    hit_seen_s = 1'b1;
                end else begin
                    hit_seen_s = hit_seen_r;
                end
            end
            COOLDOWN: begin
                hit_seen_s = 1'b0;
                if (frame_end) begin
                    if (cool_cnt_r <= 8'd1) begin
                        cool_cnt_s = 8'd0;
                        state_s    = PLAY;
                    end else begin
                        cool_cnt_s = cool_cnt_r - 8'd1;
                    end
                end else begin
                    cool_cnt_s = cool_cnt_r;
                end
            end
            OVER: begin
                hit_seen_s = 1'b0;
                state_s    = OVER;
            end
            default: begin
                hit_seen_s = 1'b0;
                state_s    = PLAY;
            end
        endcase
    end

    assign hit_pulse  = hit_pulse_r;
    assign lives      = lives_r;
    assign invincible = invincible_r;
    assign game_over  = game_over_r;
    assign state      = state_r;

endmodule

// File: rtl/race_compositor.sv
// Final-pixel compositor: aligns scan coordinates with the sprite/road pixels,
// selects the visible colour, and feeds overlap/frame-end events to hit_fsm.
module race_compositor
    import race_compositor_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pix_row,
    input  logic [9:0]  pix_col,
    input  logic        video_on,
    input  logic [11:0] road_pixel,
    input  logic [11:0] player_pixel,
    input  logic        player_opaque,
    input  logic [11:0] obst_pixel,
    input  logic        obst_opaque,
    output logic [11:0] vga_rgb,
    output logic        hit_pulse,
    output logic [2:0]  lives,
    output logic        invincible,
    output logic        game_over
);

    logic [9:0]  row_a_r;
    logic [9:0]  col_a_r;
    logic        video_on_a_r;
    logic [7:0]  frame_cnt_r;
    logic [11:0] vga_rgb_r;
    logic [11:0] rgb_s;
    logic [1:0]  state_s;
    logic        frame_end_s;
    logic        overlap_s;
    logic        player_visible_s;

    // Align stage: delay coordinates one cycle to meet the sprite/road pixel data.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_a_r      <= 10'd0;
            col_a_r      <= 10'd0;
            video_on_a_r <= 1'b0;
        end else begin
            row_a_r      <= pix_row;
            col_a_r      <= pix_col;
            video_on_a_r <= video_on;
        end
    end

    assign frame_end_s = video_on_a_r
                       && (row_a_r == 10'(V_ACTIVE - 1))
                       && (col_a_r == 10'(H_ACTIVE - 1));

    // Overlap uses raw opacity so a blinked-out player can still collide.
    assign overlap_s = video_on_a_r & player_opaque & obst_opaque;

    assign player_visible_s = !((state_s == 2'(COOLDOWN)) && frame_cnt_r[BLINK_SHIFT]);

    // Frame counter drives the blink phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r <= 8'd0;
        end else if (frame_end_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Pixel priority select: blanking, player, obstacle, road.
    always_comb begin
        rgb_s = BLACK;
        if (!video_on_a_r) begin
            rgb_s = BLACK;
        end else if (player_opaque && player_visible_s) begin
            rgb_s = player_pixel;
        end else if (obst_opaque) begin
            rgb_s = obst_pixel;
        end else begin
            rgb_s = road_pixel;
        end
    end

    // Output stage register.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_rgb_r <= BLACK;
        end else begin
            vga_rgb_r <= rgb_s;
        end
    end

    hit_fsm u_hit_fsm (
        .clk        (clk),
        .reset      (reset),
        .overlap    (overlap_s),
        .frame_end  (frame_end_s),
        .hit_pulse  (hit_pulse),
        .lives      (lives),
        .invincible (invincible),
        .game_over  (game_over),
        .state      (state_s)
    );

    assign vga_rgb = vga_rgb_r;

endmodule

// File: tb/tb_race_compositor.sv
// Directed bench for race_compositor: blanking, priority, hit scoring,
// cooldown blink/immunity, mid-frame reset and game over.
module tb_race_compositor;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pix_row;
    logic [9:0]  pix_col;
    logic        video_on;
    logic [11:0] road_pixel;
    logic [11:0] player_pixel;
    logic        player_opaque;
    logic [11:0] obst_pixel;
    logic        obst_opaque;
    logic [11:0] vga_rgb;
    logic        hit_pulse;
    logic [2:0]  lives;
    logic        invincible;
    logic        game_over;

    int total = 0;
    int bad   = 0;
    int fc    = 0;

    always #5 clk = ~clk;

    race_compositor dut (
        .clk           (clk),
        .reset         (reset),
        .pix_row       (pix_row),
        .pix_col       (pix_col),
        .video_on      (video_on),
        .road_pixel    (road_pixel),
        .player_pixel  (player_pixel),
        .player_opaque (player_opaque),
        .obst_pixel    (obst_pixel),
        .obst_opaque   (obst_opaque),
        .vga_rgb       (vga_rgb),
        .hit_pulse     (hit_pulse),
        .lives         (lives),
        .invincible    (invincible),
        .game_over     (game_over)
    );

    // Present one coordinate, then its pixel data a cycle later; returns when vga_rgb holds the result.
    task automatic pix(input logic [9:0] r, input logic [9:0] c, input logic von,
                       input logic [11:0] road, input logic [11:0] pl, input logic plo,
                       input logic [11:0] ob, input logic obo);
        @(negedge clk);
        pix_row = r; pix_col = c; video_on = von;
        road_pixel = 12'h000; player_pixel = 12'h000; player_opaque = 1'b0;
        obst_pixel = 12'h000; obst_opaque = 1'b0;
        @(negedge clk);
        pix_row = 10'd0; pix_col = 10'd0; video_on = 1'b0;
        road_pixel = road; player_pixel = pl; player_opaque = plo;
        obst_pixel = ob; obst_opaque = obo;
        @(negedge clk);
        road_pixel = 12'h000; player_pixel = 12'h000; player_opaque = 1'b0;
        obst_pixel = 12'h000; obst_opaque = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pix_row = 10'd0; pix_col = 10'd0; video_on = 1'b0;
        road_pixel = 12'h000; player_pixel = 12'h000; player_opaque = 1'b0;
        obst_pixel = 12'h000; obst_opaque = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (vga_rgb !== 12'h000) begin bad++; $display("FAIL reset_rgb got=%h exp=000", vga_rgb); end
        total++; if (lives !== 3'd3) begin bad++; $display("FAIL reset_lives got=%0d exp=3", lives); end
        total++; if ({hit_pulse, invincible, game_over} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b exp=000", {hit_pulse, invincible, game_over});
        end
        reset = 1'b0;
        fc = 0;
    endtask

    task automatic test_blanking();
        pix(10'd100, 10'd320, 1'b0, 12'h444, 12'h0F0, 1'b1, 12'hF00, 1'b1);
        total++; if (vga_rgb !== 12'h000) begin bad++; $display("FAIL blanking got=%h exp=000", vga_rgb); end
    endtask

    task automatic test_priority();
        pix(10'd100, 10'd320, 1'b1, 12'h444, 12'h0F0, 1'b1, 12'hF00, 1'b1);
        total++; if (vga_rgb !== 12'h0F0) begin bad++; $display("FAIL prio_player got=%h exp=0F0", vga_rgb); end
        pix(10'd100, 10'd320, 1'b1, 12'h444, 12'h0F0, 1'b0, 12'hF00, 1'b1);
        total++; if (vga_rgb !== 12'hF00) begin bad++; $display("FAIL prio_obst got=%h exp=F00", vga_rgb); end
        pix(10'd101, 10'd321, 1'b1, 12'h444, 12'h0F0, 1'b0, 12'hF00, 1'b0);
        total++; if (vga_rgb !== 12'h444) begin bad++; $display("FAIL prio_road got=%h exp=444", vga_rgb); end
        // The overlap above must be discarded by reset before the frame ends.
        do_reset();
        pix(10'd479, 10'd639, 1'b1, 12'h123, 12'h0F0, 1'b0, 12'hF00, 1'b0);
        fc++;
        total++; if (vga_rgb !== 12'h123) begin bad++; $display("FAIL fe_road got=%h exp=123", vga_rgb); end
        total++; if (hit_pulse !== 1'b0 || lives !== 3'd3) begin
            bad++; $display("FAIL discard_partial got pulse=%b lives=%0d exp pulse=0 lives=3", hit_pulse, lives);
        end
    endtask

    task automatic test_single_hit();
        for (int i = 0; i < 5; i++) begin
            pix(10'(50 + i), 10'(60 + 3 * i), 1'b1, 12'h444, 12'h0F0, 1'b1, 12'hF00, 1'b1);
        end
        total++; if (vga_rgb !== 12'h0F0) begin bad++; $display("FAIL hit_rgb got=%h exp=0F0", vga_rgb); end
        pix(10'd479, 10'd639, 1'b1, 12'h444, 12'h0F0, 1'b0, 12'hF00, 1'b0);
        fc++;
        total++; if (hit_pulse !== 1'b1) begin bad++; $display("FAIL hit_pulse got=%b exp=1", hit_pulse); end
        total++; if (lives !== 3'd2) begin bad++; $display("FAIL hit_lives got=%0d exp=2", lives); end
        total++; if (invincible !== 1'b1) begin bad++; $display("FAIL hit_inv got=%b exp=1", invincible); end
        @(negedge clk);
        total++; if (hit_pulse !== 1'b0) begin bad++; $display("FAIL pulse_width got=%b exp=0", hit_pulse); end
    endtask

    // Sixty cooldown frames with overlaps everywhere; checks blink and immunity each frame.
    task automatic run_cooldown(input logic [2:0] exp_lives);
        logic [11:0] exp_rgb;
        logic [7:0]  fcb;
        for (int k = 1; k <= 60; k++) begin
            fcb = 8'(fc);
            exp_rgb = fcb[3] ? 12'hF00 : 12'h0F0;
            pix(10'd200, 10'd300, 1'b1, 12'h444, 12'h0F0, 1'b1, 12'hF00, 1'b1);
            total++; if (vga_rgb !== exp_rgb) begin
                bad++; $display("FAIL blink k=%0d got=%h exp=%h", k, vga_rgb, exp_rgb);
            end
            pix(10'd479, 10'd639, 1'b1, 12'h444, 12'h0F0, 1'b1, 12'hF00, 1'b1);
            fc++;
            total++; if (hit_pulse !== 1'b0 || lives !== exp_lives || invincible !== (k < 60)) begin
                bad++; $display("FAIL cool k=%0d got pulse=%b lives=%0d inv=%b exp pulse=0 lives=%0d inv=%b",
                                k, hit_pulse, lives, invincible, exp_lives, (k < 60));
            end
        end
    endtask

    // Hit scored solely by an overlap on the frame-end pixel.
    task automatic frame_end_hit(input logic [2:0] exp_lives, input logic exp_over);
        pix(10'd479, 10'd639, 1'b1, 12'h444, 12'h0F0, 1'b1, 12'hF00, 1'b1);
        fc++;
        total++; if (vga_rgb !== 12'h0F0) begin bad++; $display("FAIL fe_hit_rgb got=%h exp=0F0", vga_rgb); end
        total++; if (hit_pulse !== 1'b1 || lives !== exp_lives) begin
            bad++; $display("FAIL fe_hit got pulse=%b lives=%0d exp pulse=1 lives=%0d", hit_pulse, lives, exp_lives);
        end
        total++; if (game_over !== exp_over || invincible !== !exp_over) begin
            bad++; $display("FAIL fe_hit_state got over=%b inv=%b exp over=%b inv=%b",
                            game_over, invincible, exp_over, !exp_over);
        end
    endtask

    task automatic test_cooldown();
        run_cooldown(3'd2);
        frame_end_hit(3'd1, 1'b0);
    endtask

    task automatic test_reset_mid();
        pix(10'd30, 10'd40, 1'b1, 12'h444, 12'h0F0, 1'b1, 12'hF00, 1'b1);
        pix_row = 10'd31; pix_col = 10'd40; video_on = 1'b1;
        road_pixel = 12'h555; player_opaque = 1'b1; player_pixel = 12'h0F0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        video_on = 1'b0; player_opaque = 1'b0;
        fc = 0;
        total++; if (lives !== 3'd3 || invincible !== 1'b0) begin
            bad++; $display("FAIL mid_reset got lives=%0d inv=%b exp lives=3 inv=0", lives, invincible);
        end
        total++; if (vga_rgb !== 12'h000 || hit_pulse !== 1'b0 || game_over !== 1'b0) begin
            bad++; $display("FAIL mid_reset_out got rgb=%h pulse=%b over=%b exp 000/0/0", vga_rgb, hit_pulse, game_over);
        end
    endtask

    task automatic test_game_over();
        frame_end_hit(3'd2, 1'b0);
        run_cooldown(3'd2);
        frame_end_hit(3'd1, 1'b0);
        run_cooldown(3'd1);
        frame_end_hit(3'd0, 1'b1);
        @(negedge clk);
        total++; if (hit_pulse !== 1'b0) begin bad++; $display("FAIL over_pulse_width got=%b exp=0", hit_pulse); end
        pix(10'd10, 10'd10, 1'b1, 12'h444, 12'h0F0, 1'b1, 12'hF00, 1'b1);
        total++; if (vga_rgb !== 12'h0F0) begin bad++; $display("FAIL over_rgb got=%h exp=0F0", vga_rgb); end
        pix(10'd479, 10'd639, 1'b1, 12'h444, 12'h0F0, 1'b1, 12'hF00, 1'b1);
        total++; if (hit_pulse !== 1'b0 || lives !== 3'd0 || game_over !== 1'b1) begin
            bad++; $display("FAIL over_sticky got pulse=%b lives=%0d over=%b exp 0/0/1", hit_pulse, lives, game_over);
        end
        pix(10'd5, 10'd6, 1'b1, 12'h777, 12'h0F0, 1'b0, 12'hF00, 1'b1);
        total++; if (vga_rgb !== 12'hF00) begin bad++; $display("FAIL over_obst got=%h exp=F00", vga_rgb); end
    endtask

    initial begin
        test_reset();
        test_blanking();
        test_priority();
        test_single_hit();
        test_cooldown();
        test_reset_mid();
        test_game_over();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
